// File: rtl/ibuffer_enqer.sv
// Instruction-buffer storage and enqueue side: a 16-parcel queue with head at entry 0.
// It compacts fetch packets, appends them at the tail and shifts out dequeued parcels.
// Optional stall counter output is enabled by defining IBUFFER_ENQER_PERF_EN.
module ibuffer_enqer #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ENQ_WIDTH = 8
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        enq_valid,
  input  logic [ENQ_WIDTH-1:0]        enq_parcel_valid_vec,
  input  logic [ENQ_WIDTH-1:0][15:0]  enq_parcel_vec,
  output logic                        enq_ready,
  input  logic                        deq_valid,
  input  logic [4:0]                  deq_parcel_count,
  input  logic                        flush,
  output logic [DEPTH-1:0]            valid_vec,
  output logic [DEPTH-1:0]            uncompressed_vec,
  output logic [DEPTH-1:0][15:0]      parcel_vec,
  output logic [4:0]                  occupancy
`ifdef IBUFFER_ENQER_PERF_EN
  ,
  output logic [31:0]                 perf_stall_count
`endif
);

  localparam int unsigned IW = $clog2(ENQ_WIDTH);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [4:0]                 r_occ;
  logic [DEPTH-1:0][15:0]     r_parcel;
  logic [DEPTH-1:0]           r_uncomp;

  logic [ENQ_WIDTH-1:0][15:0] w_packed;
  logic [4:0]                 w_enq_count;
  logic                       w_ready;
  logic                       w_fire;
  logic [4:0]                 w_deq_req;
  logic [4:0]                 w_eff;
  logic [4:0]                 w_base;
  logic [4:0]                 w_add;
  logic [4:0]                 w_src;
  logic [4:0]                 w_off;
  logic [DEPTH-1:0][15:0]     w_parcel_d;
  logic [DEPTH-1:0]           w_uncomp_d;

  // Ready is a function of registered occupancy only, so a full packet always fits.
  assign w_ready   = (r_occ <= 5'(DEPTH - ENQ_WIDTH));
  assign w_fire    = enq_valid & w_ready;
  assign w_deq_req = deq_valid ? deq_parcel_count : 5'd0;
  assign w_eff     = (w_deq_req > r_occ) ? r_occ : w_deq_req;
  assign w_base    = r_occ - w_eff;
  assign w_add     = w_fire ? w_enq_count : 5'd0;

  // Pack valid parcels LSB-first, preserving their original order.
  always_comb begin
    w_packed    = '0;
    w_enq_count = '0;
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      if (enq_parcel_valid_vec[i]) begin
        w_packed[w_enq_count[IW-1:0]] = enq_parcel_vec[i];
        w_enq_count = w_enq_count + 5'd1;
      end
    end
  end

  always_comb begin
    w_parcel_d = r_parcel;
    w_uncomp_d = r_uncomp;
    w_src      = '0;
    w_off      = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_src = 5'(j) + w_eff;
      w_off = 5'(j) - w_base;
      if (5'(j) < w_base) begin
        w_parcel_d[j] = r_parcel[w_src[AW-1:0]];
        w_uncomp_d[j] = r_uncomp[w_src[AW-1:0]];
      end else if (w_off < w_add) begin
        w_parcel_d[j] = w_packed[w_off[IW-1:0]];
        w_uncomp_d[j] = &w_packed[w_off[IW-1:0]][1:0];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_occ    <= '0;
      r_parcel <= '0;
      r_uncomp <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else begin
      r_occ    <= w_base + w_add;
      r_parcel <= w_parcel_d;
      r_uncomp <= w_uncomp_d;
    end
  end

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = (5'(i) < r_occ);
    end
  end

  assign enq_ready        = w_ready;
  assign occupancy        = r_occ;
  assign parcel_vec       = r_parcel;
  assign uncompressed_vec = r_uncomp;

`ifdef IBUFFER_ENQER_PERF_EN
  logic [31:0] r_stall;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall <= '0;
    end else if (enq_valid && !w_ready && !flush && (r_stall != 32'hFFFF_FFFF)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign perf_stall_count = r_stall;
`endif

endmodule

// File: tb/tb_ibuffer_enqer.sv
// Self-checking bench for ibuffer_enqer: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_ibuffer_enqer;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             enq_valid;
  logic [7:0]       enq_parcel_valid_vec;
  logic [7:0][15:0] enq_parcel_vec;
  logic             enq_ready;
  logic             deq_valid;
  logic [4:0]       deq_parcel_count;
  logic             flush;
  logic [15:0]      valid_vec;
  logic [15:0]      uncompressed_vec;
  logic [15:0][15:0] parcel_vec;
  logic [4:0]       occupancy;
`ifdef IBUFFER_ENQER_PERF_EN
  logic [31:0]      perf_stall_count;
`endif

  ibuffer_enqer #(.DEPTH(16), .ENQ_WIDTH(8)) u_dut (
    .CLK                  (CLK),
    .nRST                 (nRST),
    .enq_valid            (enq_valid),
    .enq_parcel_valid_vec (enq_parcel_valid_vec),
    .enq_parcel_vec       (enq_parcel_vec),
    .enq_ready            (enq_ready),
    .deq_valid            (deq_valid),
    .deq_parcel_count     (deq_parcel_count),
    .flush                (flush),
    .valid_vec            (valid_vec),
    .uncompressed_vec     (uncompressed_vec),
    .parcel_vec           (parcel_vec),
    .occupancy            (occupancy)
`ifdef IBUFFER_ENQER_PERF_EN
    ,
    .perf_stall_count     (perf_stall_count)
`endif
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] q[$];
  longint exp_perf = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    enq_valid            = 1'b0;
    enq_parcel_valid_vec = '0;
    enq_parcel_vec       = '0;
    deq_valid            = 1'b0;
    deq_parcel_count     = '0;
    flush                = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [255:0] got_p, exp_p;
    logic [15:0]  got_u, exp_u, exp_v;
    int sz;
    sz = q.size();
    got_p = '0; exp_p = '0; got_u = '0; exp_u = '0; exp_v = '0;
    for (int i = 0; i < sz; i++) begin
      exp_v[i]        = 1'b1;
      exp_p[i*16+:16] = q[i];
      got_p[i*16+:16] = parcel_vec[i];
      exp_u[i]        = (q[i][1:0] == 2'b11);
      got_u[i]        = uncompressed_vec[i];
    end
    check({tag, ".occ"},   256'(occupancy), 256'(sz));
    check({tag, ".valid"}, 256'(valid_vec), 256'(exp_v));
    check({tag, ".ready"}, 256'(enq_ready), 256'(sz <= 8));
    check({tag, ".data"},  got_p, exp_p);
    check({tag, ".uncmp"}, 256'(got_u), 256'(exp_u));
`ifdef IBUFFER_ENQER_PERF_EN
    check({tag, ".perf"},  256'(perf_stall_count), 256'(exp_perf));
`endif
  endtask

  // Apply current inputs for one clock; model and DUT both advance, then compare.
  task automatic tick(input string tag);
    int sz, eff;
    bit rdy;
    sz  = q.size();
    rdy = (sz <= 8);
    if (enq_valid && !rdy && !flush && exp_perf < 64'hFFFF_FFFF) exp_perf++;
    if (flush) begin
      q.delete();
    end else begin
      eff = deq_valid ? ((int'(deq_parcel_count) > sz) ? sz : int'(deq_parcel_count)) : 0;
      for (int k = 0; k < eff; k++) void'(q.pop_front());
      if (enq_valid && rdy) begin
        for (int i = 0; i < 8; i++) if (enq_parcel_valid_vec[i]) q.push_back(enq_parcel_vec[i]);
      end
    end
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic enq_pkt(input logic [7:0] vmask, input logic [15:0] base);
    enq_valid            = 1'b1;
    enq_parcel_valid_vec = vmask;
    for (int i = 0; i < 8; i++) enq_parcel_vec[i] = base + 16'(i);
  endtask

  task automatic do_flush();
    clear_in();
    flush = 1'b1;
    tick("flush");
    clear_in();
  endtask

  initial begin
    clear_in();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst.data", 256'(parcel_vec), 256'd0);
    nRST = 1'b1;
    check_all("reset");

    // Fill with 1..8, all valid
    enq_pkt(8'hFF, 16'h0001);
    tick("fill8");
    check("fill8.p7", 256'(parcel_vec[7]), 256'(16'h0008));
    check("fill8.vv", 256'(valid_vec), 256'(16'h00FF));
    do_flush();

    // Sparse compaction
    enq_pkt(8'b1010_0101, 16'hA000);
    tick("sparse");
    check("sparse.e3", 256'(parcel_vec[3]), 256'(16'hA007));
    do_flush();

    // Back-pressure at occupancy 9
    enq_pkt(8'hFF, 16'h1000); tick("bp.a");
    enq_pkt(8'h01, 16'h2000); tick("bp.b");
    enq_pkt(8'hFF, 16'h3000); tick("bp.stall");
    check("bp.occ9", 256'(occupancy), 256'd9);
    deq_valid = 1'b1; deq_parcel_count = 5'd4; tick("bp.deq4");
    check("bp.occ5", 256'(occupancy), 256'd5);
    deq_valid = 1'b0; tick("bp.accept");
    check("bp.occ13", 256'(occupancy), 256'd13);
    do_flush();

    // Simultaneous enq + deq
    enq_pkt(8'hFF, 16'h5000); tick("sim.fill");
    enq_pkt(8'hFF, 16'h6000); deq_valid = 1'b1; deq_parcel_count = 5'd3; tick("sim.both");
    check("sim.e0", 256'(parcel_vec[0]), 256'(16'h5003));
    check("sim.e5", 256'(parcel_vec[5]), 256'(16'h6000));
    do_flush();

    // Clamp oversized dequeue
    enq_pkt(8'h03, 16'h7000); tick("clamp.fill");
    clear_in(); deq_valid = 1'b1; deq_parcel_count = 5'd16; tick("clamp.deq");
    clear_in();

    // Flush wins over enq and deq at occupancy 10
    enq_pkt(8'hFF, 16'h8000); tick("fl.a");
    enq_pkt(8'h03, 16'h9000); tick("fl.b");
    enq_pkt(8'hFF, 16'hA000); deq_valid = 1'b1; deq_parcel_count = 5'd2; flush = 1'b1;
    tick("fl.all");
    clear_in();

    // Uncompressed detection
    enq_valid = 1'b1; enq_parcel_valid_vec = 8'h0F;
    enq_parcel_vec[0] = 16'h0013; enq_parcel_vec[1] = 16'h0021;
    enq_parcel_vec[2] = 16'h0037; enq_parcel_vec[3] = 16'h0042;
    tick("uncmp");
    check("uncmp.low4", 256'(uncompressed_vec[3:0]), 256'(4'b0101));
    clear_in();

    // Asynchronous reset between clock edges
    #2;
    nRST = 1'b0;
    #1;
    check("arst.occ",  256'(occupancy), 256'd0);
    check("arst.vv",   256'(valid_vec), 256'd0);
    check("arst.uv",   256'(uncompressed_vec), 256'd0);
    check("arst.data", 256'(parcel_vec), 256'd0);
    q.delete();
    exp_perf = 0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    check_all("post_rst");

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      enq_valid            = ($urandom_range(0, 3) != 0);
      enq_parcel_valid_vec = 8'($urandom);
      for (int i = 0; i < 8; i++) enq_parcel_vec[i] = 16'($urandom);
      deq_valid            = ($urandom_range(0, 2) == 0);
      deq_parcel_count     = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 16))
                                                         : 5'($urandom_range(0, 4));
      flush                = ($urandom_range(0, 39) == 0);
      tick("rand");
    end
    clear_in();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
